bsg_nor3_rr_picker: RTL and testbench

Registered round-robin picker that sits directly downstream of the bitwise 3-input NOR stage. That stage ORs three busy/occupied vectors and inverts the result, producing a free-slot mask. This block accepts the mask through a valid/ready handshake and selects one free slot per transaction using rotating priority. It presents the result (index, one-hot, none-free flag) through a one-entry registered output with a valid/yumi handshake.

---
 rtl/bsg_nor3_rr_picker.sv | 97 +++++++++
 tb/tb_bsg_nor3_rr_picker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bsg_nor3_rr_picker.sv
// Round-robin free-slot picker with a one-entry registered result (valid/yumi out, valid/ready in).
// The rotating pointer starts the search just past the most recent grant.
module bsg_nor3_rr_picker #(
    parameter int width_p     = 64,
    parameter int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     free_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] grant_id_o,
    output logic [width_p-1:0]     grant_one_hot_o,
    output logic                   none_o,
    input  logic                   yumi_i
);

    localparam logic [lg_width_lp:0]   width_lp = (lg_width_lp+1)'(width_p);
    localparam logic [lg_width_lp-1:0] last_lp  = lg_width_lp'(width_p - 1);

    logic [lg_width_lp-1:0] ptr_r;
    logic                   v_r;
    logic [lg_width_lp-1:0] grant_id_r;
    logic [width_p-1:0]     grant_one_hot_r;
    logic                   none_r;

    logic                   accept_s;
    logic                   found_s;
    logic [lg_width_lp:0]   idx_s;
    logic [lg_width_lp-1:0] pick_id_s;
    logic [lg_width_lp-1:0] ptr_next_s;

    assign ready_o  = ~v_r | yumi_i;
    assign accept_s = v_i & ready_o;

    // Rotating-priority search: offsets 0..width_p-1 from ptr_r, wrapped modulo width_p.
    always_comb begin
        found_s   = 1'b0;
        pick_id_s = {lg_width_lp{1'b0}};
        idx_s     = {(lg_width_lp+1){1'b0}};
        for (int i = 0; i < width_p; i++) begin
            idx_s = {1'b0, ptr_r} + (lg_width_lp+1)'(i);
            if (idx_s >= width_lp) begin
                idx_s = idx_s - width_lp;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && free_i[idx_s[lg_width_lp-1:0]]) begin
                found_s   = 1'b1;
                pick_id_s = idx_s[lg_width_lp-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Pointer successor of the pick, wrapping explicitly so non-power-of-two widths stay in range.
    always_comb begin
        if (pick_id_s == last_lp) begin
            ptr_next_s = {lg_width_lp{1'b0}};
        end else begin
            ptr_next_s = pick_id_s + lg_width_lp'(1);
        end
    end

    // Result register and priority pointer; accept takes precedence over a plain yumi.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_r             <= 1'b0;
            grant_id_r      <= {lg_width_lp{1'b0}};
            grant_one_hot_r <= {width_p{1'b0}};
            none_r          <= 1'b0;
            ptr_r           <= {lg_width_lp{1'b0}};
        end else if (accept_s) begin
            v_r <= 1'b1;
            if (found_s) begin
                grant_id_r      <= pick_id_s;
                grant_one_hot_r <= {{(width_p-1){1'b0}}, 1'b1} << pick_id_s;
                none_r          <= 1'b0;
                ptr_r           <= ptr_next_s;
            end else begin
                grant_id_r      <= {lg_width_lp{1'b0}};
                grant_one_hot_r <= {width_p{1'b0}};
                none_r          <= 1'b1;
            end
        end else if (yumi_i) begin
            v_r <= 1'b0;
        end
    end

    assign v_o             = v_r;
    assign grant_id_o      = grant_id_r;
    assign grant_one_hot_o = grant_one_hot_r;
    assign none_o          = none_r;

endmodule

// File: tb/tb_bsg_nor3_rr_picker.sv
// Directed bench for bsg_nor3_rr_picker at width 8: reset, rotation, wrap, none-free,
// backpressure and asynchronous reset mid-flight.
module tb_bsg_nor3_rr_picker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] free = 8'h00;
    logic       v_in = 1'b0;
    logic       ready;
    logic       v_out;
    logic [2:0] grant_id;
    logic [7:0] grant_one_hot;
    logic       none;
    logic       yumi = 1'b0;

    int total  = 0;
    int passed = 0;

    bsg_nor3_rr_picker #(.width_p(8)) dut (
        .clk_i(clk), .reset_i(reset), .free_i(free), .v_i(v_in), .ready_o(ready),
        .v_o(v_out), .grant_id_o(grant_id), .grant_one_hot_o(grant_one_hot),
        .none_o(none), .yumi_i(yumi)
    );

    always #5 clk = ~clk;

    // yumi with no valid result is a consumer protocol error
    always @(posedge clk) begin
        if (!reset && yumi && !v_out) begin
            total++;
            $error("FAIL yumi_without_v: observed yumi=1 with v_o=0, required no yumi");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [2:0] id,
                           input logic [7:0] oh, input logic nf, input logic [2:0] ptr);
        check({tag, ".v_o"},      32'(v_out),         32'(v));
        check({tag, ".id"},       32'(grant_id),      32'(id));
        check({tag, ".one_hot"},  32'(grant_one_hot), 32'(oh));
        check({tag, ".none"},     32'(none),          32'(nf));
        check({tag, ".ptr"},      32'(dut.ptr_r),     32'(ptr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset / idle
        step();
        step();
        chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        check("reset.ready", 32'(ready), 32'd1);
        reset = 1'b0;
        step();
        chk_all("idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

        // rotation with all-ones mask: 0..7,0,1 then 2..5 to bring ptr to 6
        for (int i = 0; i < 14; i++) begin
            free = 8'hFF;
            v_in = 1'b1;
            yumi = (i > 0) ? 1'b1 : 1'b0;
            step();
            chk_all("rotate", 1'b1, 3'(i % 8), 8'h01 << (i % 8), 1'b0, 3'((i + 1) % 8));
        end

        // skip and wrap from ptr 6
        free = 8'h05;
        step();
        chk_all("wrap", 1'b1, 3'd0, 8'h01, 1'b0, 3'd1);
        step();
        chk_all("skip", 1'b1, 3'd2, 8'h04, 1'b0, 3'd3);

        // none free at ptr 3, then all-ones resumes at 3
        free = 8'h00;
        step();
        chk_all("none", 1'b1, 3'd0, 8'h00, 1'b1, 3'd3);
        free = 8'hFF;
        step();
        chk_all("after_none", 1'b1, 3'd3, 8'h08, 1'b0, 3'd4);

        // backpressure
        free = 8'h10;
        step();
        chk_all("bp_first", 1'b1, 3'd4, 8'h10, 1'b0, 3'd5);
        yumi = 1'b0;
        free = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.ready", 32'(ready), 32'd0);
            chk_all("bp_hold", 1'b1, 3'd4, 8'h10, 1'b0, 3'd5);
        end
        yumi = 1'b1;
        #1;
        check("bp.ready_on_yumi", 32'(ready), 32'd1);
        step();
        chk_all("bp_release", 1'b1, 3'd0, 8'h01, 1'b0, 3'd1);

        // bring ptr to 5 with a pending result, then async reset between edges
        free = 8'h10;
        step();
        chk_all("pre_reset", 1'b1, 3'd4, 8'h10, 1'b0, 3'd5);
        yumi = 1'b0;
        v_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        check("async_reset.ready", 32'(ready), 32'd1);
        #1;
        reset = 1'b0;
        free = 8'hFF;
        v_in = 1'b1;
        step();
        chk_all("post_reset", 1'b1, 3'd0, 8'h01, 1'b0, 3'd1);
        v_in = 1'b0;
        yumi = 1'b1;
        step();
        check("drain.v_o", 32'(v_out), 32'd0);
        check("drain.ptr", 32'(dut.ptr_r), 32'd1);
        yumi = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
